// File: rtl/intr_arb_pkg.sv
// Shared definitions for the interrupt request arbiter and the handler FSM.
// State encoding of the arbiter plus the handler cc_mux command codes.
package intr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        HOLDOFF = 2'd3
    } arb_state_e;

    localparam logic [1:0] CC_NOP   = 2'b00;
    localparam logic [1:0] CC_ENIN  = 2'b01;
    localparam logic [1:0] CC_INTR  = 2'b10;
    localparam logic [1:0] CC_ACKIN = 2'b11;

endpackage

// File: rtl/intr_req_arbiter_rr_pick.sv
// Round-robin selector: finds the first set request bit starting at rr_ptr,
// wrapping modulo N_REQ. Purely combinational.
module rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             found,
    output logic [ID_W-1:0]  id
);

    int unsigned idx;

    // Scan N_REQ positions from rr_ptr; the first hit wins.
    always_comb begin
        found = 1'b0;
        id    = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % N_REQ;
            if (!found && req[ID_W'(idx)]) begin
                found = 1'b1;
                id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/intr_req_arbiter.sv
// Round-robin arbiter sharing one interrupt-handler FSM among N_REQ sources.
// Grants one source, drives the handler eql line, and holds the grant until
// the handler acknowledges and the source withdraws its request.
// Optional feature macro: INTR_ARB_TIMEOUT_EN (ASSERT/RELEASE timeout, tmo_err).
module intr_req_arbiter
    import intr_arb_pkg::*;
#(
    parameter  int unsigned N_REQ      = 4,
    parameter  int unsigned TMO_CYCLES = 16,
    parameter  int unsigned TMO_W      = 5,
    localparam int unsigned ID_W       = $clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       hnd_cc_mux,
    output logic             eql,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             tmo_err
);

    arb_state_e       state, state_nxt;
    logic             eql_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]  gnt_id_nxt;
    logic             busy_nxt;
    logic             tmo_err_nxt;
    logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;

    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic             ack;
    logic             cur_req;
    logic             tmo_hit;

    assign ack     = (hnd_cc_mux == CC_ACKIN);
    assign cur_req = req[gnt_id];

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .id     (pick_id)
    );

`ifdef INTR_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             cnt_clr;
    logic             cnt_inc;

    // Counter restarts on every state change, so each ASSERT/RELEASE entry starts at zero.
    assign cnt_clr = (state_nxt != state);
    assign cnt_inc = (state == ASSERT) || (state == RELEASE);
    assign tmo_hit = cnt_inc && (tmo_cnt == TMO_W'(TMO_CYCLES - 1));

    // Timeout counter for the ASSERT and RELEASE phases.
    always_ff @(posedge clock) begin
        if (!reset || cnt_clr) begin
            tmo_cnt <= '0;
        end else if (cnt_inc) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    localparam int unsigned UNUSED_TMO_CFG = TMO_CYCLES + TMO_W;
    assign tmo_hit = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            eql     <= 1'b0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            tmo_err <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            eql     <= eql_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= gnt_id_nxt;
            busy    <= busy_nxt;
            tmo_err <= tmo_err_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        eql_nxt     = eql;
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        busy_nxt    = busy;
        tmo_err_nxt = tmo_err;
        rr_ptr_nxt  = rr_ptr;

        unique case (state)
            IDLE: begin
                eql_nxt  = 1'b0;
                busy_nxt = 1'b0;
                if (pick_found) begin
                    state_nxt  = ASSERT;
                    eql_nxt    = 1'b1;
                    busy_nxt   = 1'b1;
                    gnt_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
                    gnt_id_nxt = pick_id;
                    if (pick_id == ID_W'(N_REQ - 1)) begin
                        rr_ptr_nxt = '0;
                    end else begin
                        rr_ptr_nxt = pick_id + 1'b1;
                    end
                end
            end

            ASSERT: begin
                if (!cur_req || ack) begin
                    state_nxt = RELEASE;
                    eql_nxt   = 1'b0;
                end else if (tmo_hit) begin
                    state_nxt   = RELEASE;
                    eql_nxt     = 1'b0;
                    tmo_err_nxt = 1'b1;
                end
            end

            RELEASE: begin
                eql_nxt = 1'b0;
                if (!ack && !cur_req) begin
                    state_nxt  = HOLDOFF;
                    gnt_nxt    = '0;
                    gnt_id_nxt = '0;
                end else if (tmo_hit) begin
                    state_nxt   = HOLDOFF;
                    gnt_nxt     = '0;
                    gnt_id_nxt  = '0;
                    tmo_err_nxt = 1'b1;
                end
            end

            HOLDOFF: begin
                state_nxt = IDLE;
                eql_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_req_arbiter.sv
// Directed self-checking bench for intr_req_arbiter.
module tb_intr_req_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [1:0] hnd_cc_mux;
    logic       eql;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       tmo_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    intr_req_arbiter #(
        .N_REQ      (4),
        .TMO_CYCLES (16),
        .TMO_W      (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .hnd_cc_mux (hnd_cc_mux),
        .eql        (eql),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req        = 4'b0000;
        hnd_cc_mux = 2'b01;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int unsigned gid;
        reset      = 1'b0;
        req        = 4'b0000;
        hnd_cc_mux = 2'b01;
        step();
        step();

        check("rst_eql", 32'(eql), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_gnt_id", 32'(gnt_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tmo_err", 32'(tmo_err), 0);
        reset = 1'b1;
        step();
        check("idle_busy", 32'(busy), 0);

        // Single request, handler acks on the third edge after the grant.
        req = 4'b0100;
        step();
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_gnt_id", 32'(gnt_id), 2);
        check("t1_eql", 32'(eql), 1);
        check("t1_busy", 32'(busy), 1);
        step();
        step();
        check("t1_eql_hold", 32'(eql), 1);
        hnd_cc_mux = 2'b11;
        step();
        check("t1_eql_ack", 32'(eql), 0);
        check("t1_gnt_rel", 32'(gnt), 32'h4);
        hnd_cc_mux = 2'b01;
        req        = 4'b0000;
        step();
        check("t1_gnt_hold_off", 32'(gnt), 0);
        check("t1_busy_hold_off", 32'(busy), 1);
        check("t1_eql_hold_off", 32'(eql), 0);
        step();
        check("t1_busy_idle", 32'(busy), 0);

        // All sources pending; each re-requests after service.
        do_reset();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            gid = 32'(i % 4);
            check("t2_gnt_id", 32'(gnt_id), gid);
            check("t2_gnt", 32'(gnt), 32'(1) << gid);
            check("t2_eql", 32'(eql), 1);
            hnd_cc_mux = 2'b11;
            step();
            hnd_cc_mux = 2'b01;
            req[gid]   = 1'b0;
            step();
            req[gid] = 1'b1;
            step();
            step();
        end

        // Source withdraws in ASSERT before any ack.
        do_reset();
        req = 4'b0010;
        step();
        check("t4_gnt", 32'(gnt), 32'h2);
        step();
        req = 4'b0000;
        step();
        check("t4_eql_abort", 32'(eql), 0);
        check("t4_gnt_rel", 32'(gnt), 32'h2);
        step();
        check("t4_gnt_hold_off", 32'(gnt), 0);
        check("t4_busy_hold_off", 32'(busy), 1);
        step();
        req = 4'b0111;
        step();
        check("t4_rr_next", 32'(gnt_id), 2);

        // Reset in the middle of ASSERT.
        do_reset();
        req = 4'b0011;
        step();
        check("t5_gnt", 32'(gnt), 32'h1);
        reset = 1'b0;
        step();
        check("t5_rst_eql", 32'(eql), 0);
        check("t5_rst_gnt", 32'(gnt), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_gnt_id", 32'(gnt_id), 0);
        reset = 1'b1;
        step();
        check("t5_regrant", 32'(gnt), 32'h1);
        check("t5_regrant_eql", 32'(eql), 1);

`ifdef INTR_ARB_TIMEOUT_EN
        // Handler never acks: timeout after 16 cycles in ASSERT.
        do_reset();
        req = 4'b0001;
        step();
        repeat (15) step();
        check("t3_eql_before_tmo", 32'(eql), 1);
        check("t3_tmo_err_before", 32'(tmo_err), 0);
        step();
        check("t3_eql_tmo", 32'(eql), 0);
        check("t3_tmo_err", 32'(tmo_err), 1);
        req = 4'b0000;
        step();
        step();
        check("t3_tmo_err_sticky", 32'(tmo_err), 1);
        do_reset();
        check("t3_tmo_err_rst", 32'(tmo_err), 0);
`else
        // Without the timeout feature the grant is held indefinitely.
        do_reset();
        req = 4'b0001;
        step();
        repeat (100) step();
        check("t6_eql_held", 32'(eql), 1);
        check("t6_gnt_held", 32'(gnt), 32'h1);
        check("t6_tmo_err", 32'(tmo_err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
